branch_resolve_bht: RTL
=======================

// Module: branch_resolve_bht
// PURPOSE
// - Next-generation branch unit: evaluates the branch condition at resolve (ID) and adds a
//   direct-mapped branch history table (BHT) of saturating counters for IF-stage prediction.
// - Compares prediction against outcome and raises mispredict/flush with the correct redirect PC.
// - Sits between the IF fetch-PC mux (lookup port) and the ID hazard/flush logic (resolve port).
// PARAMETERS
// - DATA_W     32  operand width for condition evaluation
// - PC_W       32  program-counter width
// - BHT_DEPTH  64  BHT entries, power of 2; index = pc[IDX_W+1:2], IDX_W = $clog2(BHT_DEPTH)
// - CTR_W      2   saturating-counter width; predict taken = counter MSB
// - STAT_W     32  width of the performance counters
// PORTS
// - clk              in   1       rising-edge clock
// - reset            in   1       synchronous, active-high reset
// - if_pc            in   PC_W    fetch PC for lookup
// - if_pred_taken    out  1       combinational prediction for if_pc
// - res_valid        in   1       a branch is resolving this cycle
// - res_pc           in   PC_W    PC of the resolving branch
// - res_target       in   PC_W    taken target of the resolving branch
// - res_pred_taken   in   1       prediction carried down the pipe with the branch
// - In1, In2         in   DATA_W  rs / rt operand values (already forwarded)
// - BranchOp         in   3       4 beq, 5 bne, 6 blez, 7 bgtz, 1 REGIMM; others = not a branch
// - flag             in   5       rt field for REGIMM: 5'b00001 bgez, 5'b00000 bltz, other = not taken
// - res_taken        out  1       actual outcome (0 when res_valid = 0)
// - mispredict       out  1       res_valid & (res_taken != res_pred_taken)
// - redirect_pc      out  PC_W    res_taken ? res_target : res_pc + 4
// - stat_branches    out  STAT_W  resolved-branch count
// - stat_mispredicts out  STAT_W  mispredict count
// BEHAVIOUR
// - Conditions (signed): beq In1==In2; bne In1!=In2; blez In1[MSB] | In1==0;
//   bgtz !In1[MSB] & In1!=0; bgez !In1[MSB]; bltz In1[MSB].
// - res_taken, mispredict and redirect_pc are combinational in the resolve cycle (0-cycle latency).
// - Update pipeline: on a clock edge with res_valid & BranchOp valid, capture {idx, res_taken}
//   into upd_q (upd_valid_q = 1). On the next edge, write the updated counter into the BHT:
//   increment saturating at 2^CTR_W-1 if taken; decrement saturating at 0 otherwise.
//   Total update latency is 2 edges.
// - The counter value read for an update includes any write completing on the same edge.
//   Back-to-back updates to one index therefore accumulate, with no lost update.
// - Lookup bypass: if upd_valid_q and upd index == lookup index, if_pred_taken uses the
//   post-update counter MSB, not the stale array value.
// - Lookups and updates to different indices in the same cycle are independent.
// - Stats: stat_branches += 1 per valid resolve; stat_mispredicts += 1 per mispredict.
//   Both saturate at all-ones (no wrap).
// - res_valid with an invalid BranchOp: res_taken = 0, no BHT update, not counted.
// - Reset: all BHT entries = 2'b01 (weakly not-taken), upd_valid_q = 0, stats = 0.
//   Combinational outputs follow inputs; if_pred_taken reads 0 after reset.
//   Reset mid-update drops the pending write.
// STRUCTURE
// - Package branch_pkg: BranchOp encodings (BR_BEQ/BNE/BLEZ/BGTZ/REGIMM), REGIMM rt codes,
//   CTR_INIT = 2'b01, the counter saturate-update function and the condition-evaluate function.
// - Sub-module branch_cond: the combinational condition evaluator.
// - The top holds the BHT register array, the update stage, the bypass mux and the stat counters.
// TESTING
// - Conditions: bgtz In1=0 -> 0; In1=5 -> 1; In1=32'h8000_0000 -> 0. blez In1=0 -> 1.
//   bgez/bltz on In1=-1 -> 0/1. flag=5'b00010 -> 0.
// - Training: after reset, if_pc=0x40 predicts 0. Resolve taken at pc 0x40 once -> predicts 1
//   two edges later. Five more taken -> counter stays 3. Three not-taken -> predicts 0.
// - Mispredict: res_pred_taken=1, beq In1=1, In2=2, res_pc=0x100 -> mispredict=1,
//   redirect_pc=0x104, stat_mispredicts +1.
// - Bypass: resolve taken at 0x80, then look up 0x80 in the very next cycle -> if_pred_taken=1
//   before the array write lands.
// - Aliasing / back-to-back: pcs 0x0 and 0x100 (BHT_DEPTH=64) share an entry; two consecutive
//   taken resolves move the counter 1 -> 3.
// - Reset mid-op: assert reset with upd_valid_q=1 -> entry still 2'b01 and stats 0 afterwards;
//   BranchOp=3'h2 with res_valid -> no counting.

Source files
------------

// File: rtl/branch_pkg.sv
// Branch unit shared definitions: opcode encodings,
// counter init value and condition/counter helpers.
package branch_pkg;

  localparam logic [2:0] BR_REGIMM = 3'd1;
  localparam logic [2:0] BR_BEQ    = 3'd4;
  localparam logic [2:0] BR_BNE    = 3'd5;
  localparam logic [2:0] BR_BLEZ   = 3'd6;
  localparam logic [2:0] BR_BGTZ   = 3'd7;

  localparam logic [4:0] RT_BLTZ = 5'b00000;
  localparam logic [4:0] RT_BGEZ = 5'b00001;

  localparam logic [1:0] CTR_INIT = 2'b01;

  function automatic logic br_valid(
    input logic [2:0] op
  );
    return (op == BR_REGIMM) || (op == BR_BEQ)
        || (op == BR_BNE)    || (op == BR_BLEZ)
        || (op == BR_BGTZ);
  endfunction

  // eq: In1==In2, neg: In1 sign bit, zero: In1==0
  function automatic logic br_eval(
    input logic [2:0] op,
    input logic [4:0] rt,
    input logic       eq,
    input logic       neg,
    input logic       zero
  );
    logic t;
    t = 1'b0;
    unique case (1'b1)
      (op == BR_BEQ):  t = eq;
      (op == BR_BNE):  t = !eq;
      (op == BR_BLEZ): t = neg | zero;
      (op == BR_BGTZ): t = !neg & !zero;
      (op == BR_REGIMM): begin
        if (rt == RT_BGEZ)
          t = !neg;
        else if (rt == RT_BLTZ)
          t = neg;
        else
          t = 1'b0;
      end
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Saturating up/down counter step, max = 2^w-1
  function automatic logic [7:0] ctr_next(
    input logic [7:0] c,
    input logic [7:0] max,
    input logic       taken
  );
    if (taken)
      return (c == max) ? c : c + 8'd1;
    return (c == 8'd0) ? c : c - 8'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_bht_cond.sv
// Combinational branch condition evaluator.
// Flags whether the opcode is a branch at all.
module branch_cond
  import branch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [2:0]        op,
  input  logic [4:0]        rt,
  output logic              cond,
  output logic              valid
);

  logic eq;
  logic neg;
  logic zero;

  assign eq    = (in1 == in2);
  assign neg   = in1[DATA_W-1];
  assign zero  = (in1 == '0);
  assign cond  = br_eval(op, rt, eq, neg, zero);
  assign valid = br_valid(op);

endmodule

// File: rtl/branch_resolve_bht.sv
// Branch resolve + direct-mapped BHT predictor.
// Two-edge counter update with lookup bypass.
module branch_resolve_bht
  import branch_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int CTR_W     = 2,
  parameter int STAT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              res_valid,
  input  logic [PC_W-1:0]   res_pc,
  input  logic [PC_W-1:0]   res_target,
  input  logic              res_pred_taken,
  input  logic [DATA_W-1:0] In1,
  input  logic [DATA_W-1:0] In2,
  input  logic [2:0]        BranchOp,
  input  logic [4:0]        flag,
  output logic              res_taken,
  output logic              mispredict,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [7:0] CTR_MAX =
    8'((1 << CTR_W) - 1);

  logic [CTR_W-1:0] bht [BHT_DEPTH];

  logic             upd_valid_q;
  logic [IDX_W-1:0] upd_idx_q;
  logic             upd_taken_q;

  logic             cond;
  logic             op_ok;
  logic             do_res;
  logic [IDX_W-1:0] res_idx;
  logic [IDX_W-1:0] lu_idx;
  logic [7:0]       nxt8;
  logic [CTR_W-1:0] upd_ctr;
  logic             unused;

  branch_cond #(
    .DATA_W (DATA_W)
  ) u_cond (
    .in1   (In1),
    .in2   (In2),
    .op    (BranchOp),
    .rt    (flag),
    .cond  (cond),
    .valid (op_ok)
  );

  assign do_res      = res_valid & op_ok;
  assign res_taken   = do_res & cond;
  assign mispredict  =
    res_valid & (res_taken != res_pred_taken);
  assign redirect_pc = res_taken ? res_target
                     : res_pc + PC_W'(4);

  assign res_idx = res_pc[IDX_W+1:2];
  assign lu_idx  = if_pc[IDX_W+1:2];

  assign nxt8    = ctr_next(8'(bht[upd_idx_q]),
                            CTR_MAX, upd_taken_q);
  assign upd_ctr = nxt8[CTR_W-1:0];

  assign if_pred_taken =
    (upd_valid_q && upd_idx_q == lu_idx)
      ? upd_ctr[CTR_W-1]
      : bht[lu_idx][CTR_W-1];

  assign unused = ^{if_pc[PC_W-1:IDX_W+2],
                    if_pc[1:0],
                    res_pc[PC_W-1:IDX_W+2],
                    res_pc[1:0],
                    nxt8};

  // Capture the resolved outcome for next-edge write
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
      upd_taken_q <= 1'b0;
    end else begin
      upd_valid_q <= do_res;
      if (do_res) begin
        upd_idx_q   <= res_idx;
        upd_taken_q <= res_taken;
      end
    end
  end

  // BHT array: init to weakly not-taken, apply update
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++)
        bht[i] <= CTR_W'(CTR_INIT);
    end else if (upd_valid_q) begin
      bht[upd_idx_q] <= upd_ctr;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (do_res && stat_branches != '1)
        stat_branches <= stat_branches + 1'b1;
      if (do_res && mispredict &&
          stat_mispredicts != '1)
        stat_mispredicts <= stat_mispredicts + 1'b1;
    end
  end

endmodule
